fetch_unit: RTL and testbench

- Instruction fetch stage for the 16-bit SIMPLE core, sitting directly upstream of the decoder.
- Holds the PC and issues requests to instruction memory over a req/valid handshake.
- Captures each returned word into a one-deep IR register that drives the decoder's IR input.
- Handles stalls, branch redirects with in-flight drop, and halt on HLT.

---
 rtl/simple_pkg.sv | 25 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_pkg.sv
// Shared definitions for the 16-bit SIMPLE core: opcode field constants,
// fetch FSM state encoding and the HLT recogniser.
// No ports; imported by fetch_unit (and later by the decoder).
package simple_pkg;

  // Major opcode field IR[15:14]; load/store occupy the two low prefixes.
  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b11;

  // ALU sub-operation field IR[7:4].
  localparam logic [3:0] OP3_HLT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HALT = 2'd3
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:14] == OP_ALU) && (word[7:4] == OP3_HLT);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory and holds the returned word in a one-deep IR for the decoder.
// Ports: clk/rst; stall, br_taken/br_target from downstream; imem_req/addr/rdata/valid
// to memory; IR/ir_valid/ir_pc to the decoder; halted once HLT is fetched.
module fetch_unit
  import simple_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              halted
);

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] pc;

  logic consume;
  logic slot_free;
  logic issue;      // start a new memory request this cycle
  logic load_ir;    // capture imem_rdata into IR
  logic clear_ir;   // invalidate IR (consumed or flushed)
  logic redirect;   // take br_target as the new PC

  assign consume   = ir_valid && !stall;
  assign slot_free = !ir_valid || !stall;

  // A request is outstanding exactly while waiting for or dropping a response,
  // so the request line is a pure function of state.
  assign imem_req = (state == S_WAIT) || (state == S_DROP);
  assign halted   = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    load_ir    = 1'b0;
    clear_ir   = 1'b0;
    redirect   = 1'b0;
    case (state)
      S_IDLE: begin
        if (br_taken) begin
          // No request this cycle; the target is fetched next cycle.
          redirect = 1'b1;
          clear_ir = 1'b1;
        end else begin
          if (consume)   clear_ir = 1'b1;
          if (slot_free) begin
            issue      = 1'b1;
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (br_taken) begin
          redirect   = 1'b1;
          clear_ir   = 1'b1;
          next_state = imem_valid ? S_IDLE : S_DROP;
        end else if (imem_valid) begin
          // IR is always empty here: a request is only issued while the
          // current word is being consumed or the slot is already empty.
          load_ir    = 1'b1;
          next_state = is_hlt(imem_rdata) ? S_HALT : S_IDLE;
        end else if (consume) begin
          clear_ir = 1'b1;
        end
      end
      S_DROP: begin
        if (br_taken) begin
          redirect = 1'b1;
          clear_ir = 1'b1;
        end
        if (imem_valid) next_state = S_IDLE;
      end
      S_HALT: begin
        // Branches are ignored once halted; only reset leaves this state.
        if (consume) clear_ir = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      IR        <= 16'h0000;
      ir_pc     <= '0;
      ir_valid  <= 1'b0;
    end else begin
      if (issue) imem_addr <= pc;

      if (redirect)     pc <= br_target;
      else if (load_ir) pc <= imem_addr + 1'b1;

      if (load_ir) begin
        IR       <= imem_rdata;
        ir_pc    <= imem_addr;
        ir_valid <= 1'b1;
      end else if (clear_ir) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenario tasks plus a randomized
// phase, all cross-checked every cycle by a transaction-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] IR;
  logic        ir_valid;
  logic [15:0] ir_pc;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .IR(IR), .ir_valid(ir_valid), .ir_pc(ir_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  logic [15:0] mem_tab [int];
  int          lat = 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_tab.exists(int'(a))) return mem_tab[int'(a)];
    return {2'b01, a[13:0]};   // default words are never HLT
  endfunction

  function automatic logic word_is_hlt(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  initial begin
    int  cnt;
    logic busy;
    busy = 1'b0; cnt = 0;
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        busy = 1'b0; imem_valid = 1'b0;
      end else if (imem_valid) begin
        imem_valid = 1'b0; busy = 1'b0;
      end else if (busy) begin
        cnt = cnt - 1;
        if (cnt == 0) begin imem_valid = 1'b1; imem_rdata = mem_word(imem_addr); end
      end else if (imem_req) begin
        busy = 1'b1;
        cnt  = lat - 1;
        if (cnt == 0) begin imem_valid = 1'b1; imem_rdata = mem_word(imem_addr); end
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks fetch transactions: the next address to fetch, the one outstanding
  // request (and whether a redirect has orphaned it) and the IR contents.
  logic        m_known = 1'b0;
  logic [15:0] m_pc, m_ir, m_irpc, m_req_addr;
  logic        m_irv, m_out, m_drop, m_halted;
  int          m_loads = 0;

  initial begin
    logic        s_rst, s_stall, s_br, s_vld, pre_irv, consumed;
    logic [15:0] s_tgt, w;
    forever begin
      @(posedge clk);
      s_rst = rst; s_stall = stall; s_br = br_taken; s_tgt = br_target; s_vld = imem_valid;
      #1;
      if (s_rst) begin
        m_known = 1'b1; m_pc = 16'h0000; m_ir = 16'h0000; m_irpc = 16'h0000;
        m_irv = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_halted = 1'b0; m_req_addr = 16'h0000;
      end else if (m_known) begin
        pre_irv  = m_irv;
        consumed = m_irv && !s_stall;
        if (m_halted) begin
          if (consumed) m_irv = 1'b0;
        end else if (s_br) begin
          m_pc  = s_tgt;
          m_irv = 1'b0;
          if (m_out) begin
            if (s_vld) begin m_out = 1'b0; m_drop = 1'b0; end
            else m_drop = 1'b1;
          end
        end else if (m_out && s_vld) begin
          m_out = 1'b0;
          if (m_drop) m_drop = 1'b0;
          else begin
            w = mem_word(m_req_addr);
            m_ir = w; m_irpc = m_req_addr; m_irv = 1'b1; m_pc = m_req_addr + 16'd1;
            m_loads++;
            if (word_is_hlt(w)) m_halted = 1'b1;
          end
        end else if (consumed) begin
          m_irv = 1'b0;
        end
        if (imem_req === 1'b1 && !m_out) begin
          checks++;
          if (m_halted || s_br || (pre_irv && s_stall) || imem_addr !== m_pc) begin
            errors++;
            if (errors < 40) $display("FAIL mon_issue t=%0t addr=%h expected_addr=%h halted=%0b br=%0b full_stalled=%0b",
                                      $time, imem_addr, m_pc, m_halted, s_br, pre_irv && s_stall);
          end
          m_out = 1'b1; m_req_addr = imem_addr; m_drop = 1'b0;
        end
      end
      if (m_known) begin
        checks += 6;
        if (imem_req !== m_out) begin errors++; if (errors < 40) $display("FAIL mon_req t=%0t got=%b exp=%b", $time, imem_req, m_out); end
        if (m_out && imem_addr !== m_req_addr) begin errors++; if (errors < 40) $display("FAIL mon_addr t=%0t got=%h exp=%h", $time, imem_addr, m_req_addr); end
        if (IR !== m_ir) begin errors++; if (errors < 40) $display("FAIL mon_ir t=%0t got=%h exp=%h", $time, IR, m_ir); end
        if (ir_valid !== m_irv) begin errors++; if (errors < 40) $display("FAIL mon_ir_valid t=%0t got=%b exp=%b", $time, ir_valid, m_irv); end
        if (ir_pc !== m_irpc) begin errors++; if (errors < 40) $display("FAIL mon_ir_pc t=%0t got=%h exp=%h", $time, ir_pc, m_irpc); end
        if (halted !== m_halted) begin errors++; if (errors < 40) $display("FAIL mon_halted t=%0t got=%b exp=%b", $time, halted, m_halted); end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; br_taken = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    tick(); tick();
    checks += 6;
    if (imem_req !== 1'b0)       begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    if (ir_valid !== 1'b0)       begin errors++; $display("FAIL reset_ir_valid got=%b exp=0", ir_valid); end
    if (IR !== 16'h0000)         begin errors++; $display("FAIL reset_ir got=%h exp=0000", IR); end
    if (ir_pc !== 16'h0000)      begin errors++; $display("FAIL reset_ir_pc got=%h exp=0000", ir_pc); end
    if (halted !== 1'b0)         begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    if (imem_addr !== 16'h0000)  begin errors++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
  endtask

  task automatic test_stream_stall();
    logic [15:0] words [3];
    words[0] = 16'hC000; words[1] = 16'hC110; words[2] = 16'hC220;
    lat = 1;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks += 2;
      if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin errors++; $display("FAIL stream_req%0d req=%b addr=%h exp_addr=%h", k, imem_req, imem_addr, 16'(k)); end
      if (ir_valid !== 1'b0) begin errors++; $display("FAIL stream_pulse%0d ir_valid=%b exp=0", k, ir_valid); end
      tick();
      checks++;
      if (IR !== words[k] || ir_pc !== 16'(k) || ir_valid !== 1'b1) begin
        errors++; $display("FAIL stream_ir%0d IR=%h pc=%h v=%b exp IR=%h pc=%h v=1", k, IR, ir_pc, ir_valid, words[k], 16'(k));
      end
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (IR !== 16'hC110 || ir_valid !== 1'b1 || ir_pc !== 16'h0001 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d IR=%h v=%b pc=%h req=%b exp IR=c110 v=1 pc=0001 req=0", k, IR, ir_valid, ir_pc, imem_req);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL stall_release req=%b addr=%h exp 1/0002", imem_req, imem_addr); end
    tick();
    checks++;
    if (IR !== words[2] || ir_pc !== 16'h0002) begin errors++; $display("FAIL stream_ir2 IR=%h pc=%h exp %h/0002", IR, ir_pc, words[2]); end
  endtask

  task automatic test_redirect_inflight();
    bit got;
    lat = 3;
    do_reset();
    br_taken = 1'b1; br_target = 16'h0005;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_branch_noreq req=%b exp=0", imem_req); end
    br_taken = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin errors++; $display("FAIL inflight_req req=%b addr=%h exp 1/0005", imem_req, imem_addr); end
    br_taken = 1'b1; br_target = 16'h0040;
    tick();
    br_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL drop_hold req=%b addr=%h v=%b exp 1/0005/0", imem_req, imem_addr, ir_valid);
    end
    tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL drop_discard req=%b v=%b exp 0/0", imem_req, ir_valid); end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL redirect_addr req=%b addr=%h exp 1/0040", imem_req, imem_addr); end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin tick(); if (ir_valid) got = 1'b1; end
    checks++;
    if (!got || IR !== mem_word(16'h0040) || ir_pc !== 16'h0040) begin
      errors++; $display("FAIL redirect_load got=%0b IR=%h pc=%h exp %h/0040", got, IR, ir_pc, mem_word(16'h0040));
    end
  endtask

  task automatic test_redirect_coincident();
    lat = 1;
    do_reset();
    br_taken = 1'b1; br_target = 16'h0003;   // addr 3 holds HLT
    tick();
    br_taken = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0003) begin errors++; $display("FAIL coinc_req req=%b addr=%h exp 1/0003", imem_req, imem_addr); end
    br_taken = 1'b1; br_target = 16'h0090;
    tick();
    br_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL coinc_discard req=%b v=%b halted=%b exp 0/0/0", imem_req, ir_valid, halted);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0090) begin errors++; $display("FAIL coinc_next req=%b addr=%h exp 1/0090", imem_req, imem_addr); end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || IR !== mem_word(16'h0090) || ir_pc !== 16'h0090) begin
      errors++; $display("FAIL coinc_load v=%b IR=%h pc=%h exp 1/%h/0090", ir_valid, IR, ir_pc, mem_word(16'h0090));
    end
    stall = 1'b1;
    tick();
    br_taken = 1'b1; br_target = 16'h00A0;
    tick();
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL stalled_flush v=%b req=%b exp 0/0", ir_valid, imem_req); end
    br_taken = 1'b0; stall = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h00A0) begin errors++; $display("FAIL flush_next req=%b addr=%h exp 1/00a0", imem_req, imem_addr); end
  endtask

  task automatic test_halt();
    lat = 1;
    do_reset();
    br_taken = 1'b1; br_target = 16'h0003;
    tick();
    br_taken = 1'b0;
    tick(); tick();
    checks++;
    if (IR !== 16'hC0F0 || halted !== 1'b1 || imem_req !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 16'h0003) begin
      errors++; $display("FAIL hlt_capture IR=%h halted=%b req=%b v=%b pc=%h exp c0f0/1/0/1/0003", IR, halted, imem_req, ir_valid, ir_pc);
    end
    for (int k = 0; k < 10; k++) begin
      stall = (k < 4); br_taken = (k % 2 == 0); br_target = 16'($urandom);
      tick();
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || IR !== 16'hC0F0 || ir_valid !== (k < 4)) begin
        errors++; $display("FAIL halt_hold%0d req=%b halted=%b IR=%h v=%b exp 0/1/c0f0/%0b", k, imem_req, halted, IR, ir_valid, k < 4);
      end
    end
    br_taken = 1'b0; stall = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL halt_reset halted=%b req=%b v=%b exp 0/0/0", halted, imem_req, ir_valid); end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_restart req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_midreset();
    bit got;
    lat = 1;
    do_reset();
    br_taken = 1'b1; br_target = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    tick(); tick();
    checks++;
    if (ir_pc !== 16'hFFFF || IR !== mem_word(16'hFFFF)) begin errors++; $display("FAIL wrap_load IR=%h pc=%h exp %h/ffff", IR, ir_pc, mem_word(16'hFFFF)); end
    lat = 3;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_addr req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midop_reset req=%b v=%b halted=%b exp 0/0/0", imem_req, ir_valid, halted); end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL midop_restart req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin tick(); if (ir_valid) got = 1'b1; end
    checks++;
    if (!got || IR !== 16'hC000 || ir_pc !== 16'h0000) begin errors++; $display("FAIL midop_load got=%0b IR=%h pc=%h exp c000/0000", got, IR, ir_pc); end
  endtask

  task automatic test_random();
    int loads0;
    for (int i = 0; i < 16; i++)
      mem_tab[16'h0100 + i] = ($urandom % 6 == 0) ? 16'hC0F0 : 16'($urandom);
    loads0 = m_loads;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 100 == 0) lat = 1 + int'($urandom % 4);
      stall    = ($urandom % 4 == 0);
      br_taken = ($urandom % 12 == 0);
      case ($urandom % 5)
        0, 1, 2: br_target = 16'h0100 + 16'($urandom % 16);
        3:       br_target = 16'hFFF0 + 16'($urandom % 16);
        default: br_target = 16'($urandom);
      endcase
      rst = ($urandom % 250 == 0) || (halted && ($urandom % 6 == 0));
      tick();
    end
    rst = 1'b0; br_taken = 1'b0; stall = 1'b0;
    checks++;
    if (m_loads - loads0 < 100) begin errors++; $display("FAIL random_progress loads=%0d required>=100", m_loads - loads0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
    mem_tab[0] = 16'hC000; mem_tab[1] = 16'hC110; mem_tab[2] = 16'hC220; mem_tab[3] = 16'hC0F0;
    test_reset();
    test_stream_stall();
    test_redirect_inflight();
    test_redirect_coincident();
    test_halt();
    test_wrap_midreset();
    test_random();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
